text_pixel_pipeline: RTL and testbench
======================================

Name: text_pixel_pipeline

Overview:
Parametrised next-generation text-mode pixel generator. It serialises font bytes into CHAR_W-wide character cells and keeps a one-character hold buffer, so VRAM/font fetch can run one character ahead. It also generates its own blink timing from frame strobes, supports fine horizontal panning and underline, and drives a registered colour index to the RAMDAC.

Parameters:
FONT_W, 8, font row bits per glyph
CHAR_W, 9, cell width in pixels; legal FONT_W or FONT_W+1
LINE_GFX_MSBS, 3'b110, char code MSBs that replicate font bit 0 into the extra column (CHAR_W=FONT_W+1 only)
COLOUR_W, 4, colour index width; attribute byte is 2*COLOUR_W bits
BLINK_FRAMES, 16, frames per text-blink half-period; cursor half-period = BLINK_FRAMES/2

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous active-high reset
frame_start  in  1  one-cycle pulse per frame, during blanking
line_start  in  1  one-cycle pulse; first cell of the line starts next cycle
display_enable  in  1  1 = active video pixel
load  in  1  write hold buffer with the inputs below
font_data  in  FONT_W  glyph row, MSB leftmost
attribute_data  in  2*COLOUR_W  [COLOUR_W-1:0] fg, upper half bg/blink
char_msbs  in  3  top bits of char code
cursor_active  in  1  cursor covers this cell/scanline
underline_active  in  1  underline scanline for this cell
extended_bg_colours  in  1  1 = top attribute bit is bg colour, not blink
blink_enable  in  1  0 = blink state forced on
pan  in  clog2(CHAR_W)  fine pan pixels, sampled at frame_start
overscan_colour  in  COLOUR_W  output while display_enable=0
char_req  out  1  one-cycle pulse: hold buffer consumed, fetch next
underrun  out  1  sticky; set when a cell boundary finds the hold buffer empty
colour_index  out  COLOUR_W  registered pixel colour

Behaviour:
- Reset: shift register 0, hold empty, pixel counter 0, pan_q 0, blink counter 0, text_blink=0, cursor_blink=0, char_req=0, underrun=0, colour_index=0.
- Hold buffer stores font row, attributes, MSB flag, cursor flag and underline flag. load sets hold_full. Load while full overwrites.
- Cell boundary: the cycle after line_start, or the cycle after the counter reaches CHAR_W-1. At a boundary:
  - If hold_full: transfer hold to the active registers, clear hold_full, pulse char_req the same cycle.
  - Load coinciding with a boundary is consumed directly into the active registers, with hold left empty.
  - If hold is empty and there is no load: active registers load 0 (blank cell, bg colour 0), set underrun, no char_req.
- Shift pattern is {font_data, x}, where x = font_data[0] if char_msbs==LINE_GFX_MSBS and CHAR_W>FONT_W, else 0. It is truncated to CHAR_W bits.
- Shifting: left one bit per clk, MSB is the current pixel. The counter increments per clk and wraps CHAR_W-1 -> 0.
- Pan: at the line_start boundary, the pattern is pre-shifted left by pan_q and the counter starts at pan_q. The first cell is therefore CHAR_W-pan_q pixels. Later cells are full width. pan_q changes only on frame_start.
- Blink: frame counter increments on frame_start.
  - cursor_blink toggles every BLINK_FRAMES/2 frames.
  - text_blink toggles every BLINK_FRAMES frames.
  - If blink_enable=0, both read as 1.
- Pixel select: fg when any of:
  - cursor_latch & cursor_blink
  - underline_latch
  - pixel & (extended_bg_colours | ~attr_msb | text_blink)
- bg is the upper attribute half when extended_bg_colours=1; otherwise the MSB is forced to 0.
- Output: colour_index <= display_enable ? (fg ? fg colour : bg colour) : overscan_colour. Latency is one clk from the shift MSB to colour_index.
- Counter free-runs; line_start restarts it at any time, including mid-cell.
- line_start and frame_start in the same cycle: pan sampled first, so the new pan applies to that line.
- Reset mid-line: all state cleared; underrun cleared only by reset.

Decomposition:
- Shared package text_pkg: FONT_W, CHAR_W, COLOUR_W, LINE_GFX_MSBS, attribute field positions, pan width function.
- Sub-module text_blink_timer: frame counter producing text_blink and cursor_blink.

Test Plan:
- Preload hold with font 8'hA5, attr 8'h1E, msbs 3'b000, then line_start, CHAR_W=9 -> pixels E,1,E,1,1,E,1,E,1 (E=fg, 1=bg) one clk after shift; char_req at cell start.
- msbs 3'b110, font 8'h81 -> pixel 9 = fg (E); same font with msbs 3'b101 -> pixel 9 = bg.
- pan=3 sampled at frame_start, then line_start with continuous loads -> first cell shows 6 pixels (font bits 4..0 + extra), then full 9-pixel cells; char_req spacing 6 then 9.
- No load before the second boundary -> blank cell in colour 0, underrun=1 and held, no char_req; the next load recovers the following cell.
- attr 8'h9E, ext=0: 16 frame pulses -> fg pixels alternate fg/bg every 16 frames; cursor_active toggles every 8 frames; ext=1 -> bg=9, no blink.
- display_enable=0 with overscan 4'h6 -> colour_index=6; async reset mid-cell -> all outputs 0 immediately.

Source files
------------

// File: rtl/text_pkg.sv
// text_pkg: shared geometry, attribute layout and helpers for the text-mode pixel pipeline
// Exports: FONT_W, CHAR_W, COLOUR_W, BLINK_FRAMES, LINE_GFX_MSBS, attribute field positions,
//          PAN_W via pan_width(), cell_t (one latched character) and pattern() (shift pattern).
package text_pkg;
    localparam int FONT_W = 8;
    localparam int CHAR_W = 9;
    localparam int COLOUR_W = 4;
    localparam int BLINK_FRAMES = 16;
    localparam logic [2:0] LINE_GFX_MSBS = 3'b110;
    localparam int ATTR_W = 2 * COLOUR_W;
    localparam int FG_LSB = 0;
    localparam int BG_LSB = COLOUR_W;
    localparam int BLINK_BIT = ATTR_W - 1;

    function automatic int pan_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int PAN_W = pan_width(CHAR_W);

    typedef struct packed {
        logic [FONT_W-1:0] font;
        logic [ATTR_W-1:0] attr;
        logic gfx;
        logic cursor;
        logic uline;
    } cell_t;

    // Line-graphics codes repeat the rightmost font bit into the ninth column so box
    // characters join up; narrow cells simply drop the extra column.
    function automatic logic [CHAR_W-1:0] pattern(input cell_t c);
        logic x;
        x = (CHAR_W > FONT_W) && c.gfx && c.font[0];
        return CHAR_W'({c.font, x} >> (FONT_W + 1 - CHAR_W));
    endfunction
endpackage

// File: rtl/text_blink_timer.sv
// text_blink_timer: frame counter producing the text and cursor blink phases
// Ports: clk_i, reset_i (async, active high), frame_start_i (frame strobe),
//        blink_enable_i (0 forces both phases on), text_blink_o, cursor_blink_o.
module text_blink_timer
    import text_pkg::*;
#(
    parameter int FRAMES = BLINK_FRAMES
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic frame_start_i,
    input  logic blink_enable_i,
    output logic text_blink_o,
    output logic cursor_blink_o
);
    localparam int FC_W = pan_width(FRAMES);

    logic [FC_W-1:0] fc_q, fc_d;
    logic text_q, text_d, cur_q, cur_d;
    logic last, half;

    // The cursor toggles at the middle and the end of each text half-period, so it
    // runs at twice the text rate and both phases stay aligned.
    always_comb begin
        last = fc_q == FC_W'(FRAMES - 1);
        half = fc_q == FC_W'(FRAMES / 2 - 1);
        fc_d = fc_q;
        text_d = text_q;
        cur_d = cur_q;
        if (frame_start_i) begin
            fc_d = last ? '0 : fc_q + 1'b1;
            text_d = text_q ^ last;
            cur_d = cur_q ^ (last | half);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fc_q <= '0;
            text_q <= 1'b0;
            cur_q <= 1'b0;
        end else begin
            fc_q <= fc_d;
            text_q <= text_d;
            cur_q <= cur_d;
        end
    end

    assign text_blink_o = text_q | ~blink_enable_i;
    assign cursor_blink_o = cur_q | ~blink_enable_i;
endmodule

// File: rtl/text_pixel_pipeline.sv
// text_pixel_pipeline: serialises font rows into character cells and drives a registered colour index
// Ports: clk_i, reset_i (async, active high); frame_start_i, line_start_i, display_enable_i timing;
//        load_i with font_data_i, attribute_data_i, char_msbs_i, cursor_active_i, underline_active_i
//        fill the one-character hold buffer; extended_bg_colours_i, blink_enable_i, pan_i,
//        overscan_colour_i control rendering; char_req_o asks for the next character,
//        underrun_o is sticky, colour_index_o goes to the RAMDAC.
module text_pixel_pipeline
    import text_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                frame_start_i,
    input  logic                line_start_i,
    input  logic                display_enable_i,
    input  logic                load_i,
    input  logic [FONT_W-1:0]   font_data_i,
    input  logic [ATTR_W-1:0]   attribute_data_i,
    input  logic [2:0]          char_msbs_i,
    input  logic                cursor_active_i,
    input  logic                underline_active_i,
    input  logic                extended_bg_colours_i,
    input  logic                blink_enable_i,
    input  logic [PAN_W-1:0]    pan_i,
    input  logic [COLOUR_W-1:0] overscan_colour_i,
    output logic                char_req_o,
    output logic                underrun_o,
    output logic [COLOUR_W-1:0] colour_index_o
);
    cell_t in_cell, next_c, hold_q, hold_d, act_q, act_d;
    logic hold_full_q, hold_full_d;
    logic [CHAR_W-1:0] shift_q, shift_d;
    logic [PAN_W-1:0] cnt_q, cnt_d, pan_q, pan_d, pan_eff;
    logic char_req_q, char_req_d, underrun_q, underrun_d;
    logic [COLOUR_W-1:0] colour_q, colour_d, bg_c;
    logic cell_edge, fill, fg_c, text_blink, cursor_blink;

    assign in_cell = '{font: font_data_i, attr: attribute_data_i, gfx: char_msbs_i == LINE_GFX_MSBS,
                       cursor: cursor_active_i, uline: underline_active_i};

    text_blink_timer u_blink (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .frame_start_i  (frame_start_i),
        .blink_enable_i (blink_enable_i),
        .text_blink_o   (text_blink),
        .cursor_blink_o (cursor_blink)
    );

    always_comb begin
        cell_edge = line_start_i | (cnt_q == PAN_W'(CHAR_W - 1));
        // A pan arriving with the line strobe must already apply to that line.
        pan_eff = frame_start_i ? pan_i : pan_q;
        fill = load_i | hold_full_q;
        // A load landing on a boundary bypasses the hold buffer entirely.
        next_c = load_i ? in_cell : hold_full_q ? hold_q : '0;
        pan_d = pan_eff;
        hold_d = load_i ? in_cell : hold_q;
        hold_full_d = cell_edge ? 1'b0 : fill;
        act_d = cell_edge ? next_c : act_q;
        shift_d = cell_edge ? pattern(next_c) << (line_start_i ? pan_eff : PAN_W'(0)) : shift_q << 1;
        cnt_d = line_start_i ? pan_eff : cell_edge ? '0 : cnt_q + 1'b1;
        char_req_d = cell_edge & fill;
        underrun_d = underrun_q | (cell_edge & ~fill);
        fg_c = (act_q.cursor & cursor_blink) | act_q.uline |
               (shift_q[CHAR_W-1] & (extended_bg_colours_i | ~act_q.attr[BLINK_BIT] | text_blink));
        bg_c = {act_q.attr[BLINK_BIT] & extended_bg_colours_i, act_q.attr[BLINK_BIT-1:BG_LSB]};
        colour_d = display_enable_i ? (fg_c ? act_q.attr[FG_LSB +: COLOUR_W] : bg_c) : overscan_colour_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hold_q <= '0;
            hold_full_q <= 1'b0;
            act_q <= '0;
            shift_q <= '0;
            cnt_q <= '0;
            pan_q <= '0;
            char_req_q <= 1'b0;
            underrun_q <= 1'b0;
            colour_q <= '0;
        end else begin
            hold_q <= hold_d;
            hold_full_q <= hold_full_d;
            act_q <= act_d;
            shift_q <= shift_d;
            cnt_q <= cnt_d;
            pan_q <= pan_d;
            char_req_q <= char_req_d;
            underrun_q <= underrun_d;
            colour_q <= colour_d;
        end
    end

    assign char_req_o = char_req_q;
    assign underrun_o = underrun_q;
    assign colour_index_o = colour_q;
endmodule

// File: tb/tb_text_pixel_pipeline.sv
// tb_text_pixel_pipeline: directed vector bench for the text-mode pixel pipeline
module tb_text_pixel_pipeline;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fs, ls, de, ld, cur, ul, ext, ben;
    logic [7:0] font, attr;
    logic [2:0] msbs;
    logic [3:0] pan, ovs;
    logic req, urun;
    logic [3:0] col;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  font;
        logic [7:0]  attr;
        logic [2:0]  msbs;
        logic        ext;
        logic        ul;
        logic        cur;
        logic        ben;
        logic [35:0] pix;
    } vec_t;

    vec_t vecs[10];
    logic [3:0] pan_exp[15];

    text_pixel_pipeline dut (
        .clk_i                 (clk),
        .reset_i               (reset),
        .frame_start_i         (fs),
        .line_start_i          (ls),
        .display_enable_i      (de),
        .load_i                (ld),
        .font_data_i           (font),
        .attribute_data_i      (attr),
        .char_msbs_i           (msbs),
        .cursor_active_i       (cur),
        .underline_active_i    (ul),
        .extended_bg_colours_i (ext),
        .blink_enable_i        (ben),
        .pan_i                 (pan),
        .overscan_colour_i     (ovs),
        .char_req_o            (req),
        .underrun_o            (urun),
        .colour_index_o        (col)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rst_dut();
        {fs, ls, ld, cur, ul, ext} = '0;
        de = 1'b1;
        ben = 1'b1;
        font = '0;
        attr = '0;
        msbs = '0;
        pan = '0;
        ovs = '0;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h1E, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 36'hE1E11E1E1};
        vecs[1] = '{8'h81, 8'h1E, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 36'hE111111EE};
        vecs[2] = '{8'h81, 8'h1E, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 36'hE111111E1};
        vecs[3] = '{8'hA5, 8'h9E, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 36'h111111111};
        vecs[4] = '{8'hA5, 8'h9E, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 36'hE9E99E9E9};
        vecs[5] = '{8'hA5, 8'h9E, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 36'hE1E11E1E1};
        vecs[6] = '{8'h00, 8'h5A, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 36'hAAAAAAAAA};
        vecs[7] = '{8'h00, 8'h34, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 36'h444444444};
        vecs[8] = '{8'h00, 8'h34, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 36'h333333333};
        vecs[9] = '{8'hF0, 8'hC7, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 36'h7777CCCCC};
        pan_exp = '{4'h1, 4'h1, 4'hE, 4'h1, 4'hE, 4'hE,
                    4'hE, 4'h1, 4'hE, 4'h1, 4'h1, 4'hE, 4'h1, 4'hE, 4'hE};

        rst_dut();
        chk("reset_colour", col, 0);
        chk("reset_char_req", req, 0);
        chk("reset_underrun", urun, 0);

        foreach (vecs[i]) begin
            rst_dut();
            ext = vecs[i].ext;
            ben = vecs[i].ben;
            ld = 1'b1;
            font = vecs[i].font;
            attr = vecs[i].attr;
            msbs = vecs[i].msbs;
            cur = vecs[i].cur;
            ul = vecs[i].ul;
            tick();
            ld = 1'b0;
            ls = 1'b1;
            tick();
            ls = 1'b0;
            chk($sformatf("vec%0d_char_req", i), req, 1);
            for (int k = 0; k < 9; k++) begin
                tick();
                chk($sformatf("vec%0d_pix%0d", i, k), col, vecs[i].pix[35-4*k -: 4]);
            end
        end

        // pan of 3 arriving together with the line strobe, continuous loads
        rst_dut();
        ld = 1'b1;
        font = 8'hA5;
        attr = 8'h1E;
        msbs = 3'b110;
        tick();
        ls = 1'b1;
        fs = 1'b1;
        pan = 4'd3;
        tick();
        ls = 1'b0;
        fs = 1'b0;
        pan = 4'd0;
        chk("pan_req0", req, 1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("pan_pix%0d", k - 1), col, pan_exp[k-1]);
            chk($sformatf("pan_req%0d", k), req, (k == 6 || k == 15) ? 1 : 0);
        end

        // underrun: second cell finds nothing to show, late load recovers the third
        rst_dut();
        ld = 1'b1;
        font = 8'hA5;
        attr = 8'h1E;
        msbs = 3'b000;
        tick();
        ld = 1'b0;
        ls = 1'b1;
        tick();
        ls = 1'b0;
        chk("ur_first_req", req, 1);
        repeat (9) tick();
        chk("ur_set", urun, 1);
        chk("ur_no_req", req, 0);
        for (int k = 10; k <= 18; k++) begin
            ld = (k == 17);
            tick();
            chk($sformatf("ur_blank%0d", k), col, 0);
            chk($sformatf("ur_req%0d", k), req, (k == 18) ? 1 : 0);
        end
        ld = 1'b0;
        chk("ur_sticky", urun, 1);
        tick();
        chk("ur_recover_pix", col, 4'hE);
        de = 1'b0;
        ovs = 4'h6;
        tick();
        chk("overscan", col, 4'h6);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_colour", col, 0);
        chk("async_rst_underrun", urun, 0);
        chk("async_rst_req", req, 0);

        // text blink: 16 frames flip the blinking glyph from bg to fg
        rst_dut();
        ld = 1'b1;
        font = 8'hFF;
        attr = 8'h9E;
        msbs = 3'b110;
        tick();
        ls = 1'b1;
        tick();
        ls = 1'b0;
        repeat (5) tick();
        chk("blink_off", col, 4'h1);
        fs = 1'b1;
        repeat (15) tick();
        fs = 1'b0;
        tick();
        chk("blink_15_frames", col, 4'h1);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        repeat (2) tick();
        chk("blink_16_frames", col, 4'hE);

        // cursor blink at half the period
        font = 8'h00;
        attr = 8'h34;
        msbs = 3'b000;
        cur = 1'b1;
        repeat (12) tick();
        chk("cursor_off", col, 4'h3);
        fs = 1'b1;
        repeat (7) tick();
        fs = 1'b0;
        tick();
        chk("cursor_7_frames", col, 4'h3);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        repeat (2) tick();
        chk("cursor_8_frames", col, 4'h4);
        fs = 1'b1;
        repeat (8) tick();
        fs = 1'b0;
        repeat (2) tick();
        chk("cursor_16_frames", col, 4'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
